led_prog_loader: RTL and testbench

- Writer side of the LED CPU program memory.
- Accepts a byte stream over a valid/ready handshake and packs it into 16-bit instruction words: [15:8] is the pattern or jump target, [7:0] is the duration, and 0 in [7:0] means jump.
- Writes each word into the program RAM that the LED CPU core reads.
- Holds the CPU core in reset while loading and releases it only after a load passes its checksum.

---
 rtl/led_prog_loader.sv | 202 ++++++++++++++++++++
 tb/tb_led_prog_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_prog_loader.sv
// -----------------------------------------------------------------------------
// led_prog_loader
//
// Writer side of the LED CPU program memory. A byte stream arriving over a
// valid/ready handshake is packed into 16-bit instruction words
// ({pattern_or_target, duration}; duration 0 means jump) and written to the
// program RAM. The LED CPU core is held in reset while loading and is only
// released after a load whose trailing checksum byte matches.
//
// Stream: LEN (N words, 0 = 256), N x {HI, LO}, CHK (XOR of all prior bytes).
//
// Ports
//   clk        in   system clock, all logic on posedge
//   rst        in   synchronous active-high reset
//   start      in   one-cycle pulse, begins a load from IDLE/DONE/ERR
//   byteIn     in   [7:0] stream data
//   byteValid  in   byteIn is valid
//   byteReady  out  loader accepts a byte this cycle (depends on state only)
//   addrWr     out  [7:0]  program RAM write address
//   dataWr     out  [15:0] program RAM write data
//   wrEn       out  program RAM write strobe, one cycle per word
//   cpuRst     out  reset to the LED CPU core
//   busy       out  load in progress
//   done       out  last load completed with a good checksum
//   err        out  last load failed (bad checksum or inter-byte timeout)
// -----------------------------------------------------------------------------
module led_prog_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000 / 256,
  parameter int unsigned CNT_W          = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  byteIn,
  input  logic        byteValid,
  output logic        byteReady,
  output logic [7:0]  addrWr,
  output logic [15:0] dataWr,
  output logic        wrEn,
  output logic        cpuRst,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_HI, S_LO, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_e;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [8:0]         cnt_q, cnt_d;       // remaining words, 1..256
  logic [7:0]         chk_q, chk_d;       // running XOR of the stream
  logic [CNT_W-1:0]   tmo_q, tmo_d;       // cycles since last accepted byte
  logic               ready_q, ready_d;
  logic [7:0]         addr_q, addr_d;
  logic [15:0]        data_q, data_d;
  logic               wr_en_q, wr_en_d;
  logic               cpu_rst_q, cpu_rst_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic xfer;
  logic waiting;

  // byteReady is itself a register, so the handshake only needs the flop.
  assign xfer    = byteValid && ready_q;
  assign waiting = (state_q == S_LEN) || (state_q == S_HI) ||
                   (state_q == S_LO)  || (state_q == S_CHK);

  always_comb begin
    // NOTE: every variable gets a default before the case so that paths which
    // do not assign it hold their value instead of inferring a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    chk_d     = chk_q;
    tmo_d     = '0;
    addr_d    = addr_q;
    data_d    = data_q;
    cpu_rst_d = cpu_rst_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d   = S_LEN;
          cpu_rst_d = 1'b1;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
          addr_d    = '0;
          chk_d     = '0;
        end
      end
      S_LEN: begin
        if (xfer) begin
          cnt_d   = (byteIn == 8'd0) ? 9'd256 : {1'b0, byteIn};
          chk_d   = chk_q ^ byteIn;
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (xfer) begin
          data_d[15:8] = byteIn;
          chk_d        = chk_q ^ byteIn;
          state_d      = S_LO;
        end
      end
      S_LO: begin
        if (xfer) begin
          data_d[7:0] = byteIn;
          chk_d       = chk_q ^ byteIn;
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        // The strobe is high during this single cycle; advance afterwards.
        addr_d  = addr_q + 8'd1;
        cnt_d   = cnt_q - 9'd1;
        state_d = (cnt_q == 9'd1) ? S_CHK : S_HI;
      end
      S_CHK: begin
        if (xfer) begin
          busy_d = 1'b0;
          if (byteIn == chk_q) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte watchdog. Outside the byte-waiting states the counter stays
    // cleared; an accepted byte on the final cycle takes priority.
    if (waiting && !xfer) begin
      if (tmo_q == TMO_LAST) begin
        state_d   = S_ERR;
        err_d     = 1'b1;
        busy_d    = 1'b0;
        cpu_rst_d = 1'b1;
      end else begin
        tmo_d = tmo_q + CNT_W'(1);
      end
    end

    // Registered outputs are decoded from the next state.
    wr_en_d = (state_d == S_WRITE);
    ready_d = (state_d == S_LEN) || (state_d == S_HI) ||
              (state_d == S_LO)  || (state_d == S_CHK);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register updating from the
    // same pre-edge values, independent of statement order.
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      chk_q     <= '0;
      tmo_q     <= '0;
      ready_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_en_q   <= 1'b0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      chk_q     <= chk_d;
      tmo_q     <= tmo_d;
      ready_q   <= ready_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_en_q   <= wr_en_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign byteReady = ready_q;
  assign addrWr    = addr_q;
  assign dataWr    = data_q;
  assign wrEn      = wr_en_q;
  assign cpuRst    = cpu_rst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_led_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_led_prog_loader
//
// Directed stimulus for led_prog_loader. Expected RAM writes are queued when a
// stream is built; an independent monitor pops and compares on every wrEn.
// Status outputs are compared against hand-computed values after each load.
// -----------------------------------------------------------------------------
module tb_led_prog_loader;

  localparam int T = 20;  // short watchdog so the timeout case stays quick

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byteIn = 8'h00;
  logic        byteValid = 1'b0;
  logic        byteReady;
  logic [7:0]  addrWr;
  logic [15:0] dataWr;
  logic        wrEn;
  logic        cpuRst;
  logic        busy;
  logic        done;
  logic        err;

  led_prog_loader #(
    .TIMEOUT_CYCLES(T),
    .CNT_W         (24)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .byteIn   (byteIn),
    .byteValid(byteValid),
    .byteReady(byteReady),
    .addrWr   (addrWr),
    .dataWr   (dataWr),
    .wrEn     (wrEn),
    .cpuRst   (cpuRst),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  wr_count = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the oldest queued word.
  wr_t mon_e;
  always @(negedge clk) begin
    if (wrEn === 1'b1) begin
      wr_count++;
      check("wr_ready_low", {31'd0, byteReady}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wr_unexpected actual=addr 0x%0h data 0x%0h required=no write",
                 addrWr, dataWr);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", {24'd0, addrWr}, {24'd0, mon_e.addr});
        check("wr_data", {16'd0, dataWr}, {16'd0, mon_e.data});
      end
    end
  end

  // Tasks start and end just after a falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present a byte and hold it until it is taken; valid stays high afterwards
  // unless a gap cycle is requested.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int waits = 0;
    bit acc   = 1'b0;
    byteIn    = b;
    byteValid = 1'b1;
    while (!acc && waits < 200) begin
      acc = byteReady;
      tick();
      waits++;
    end
    if (!acc) check("byte_accept_timeout", 32'd0, 32'd1);
    if (gap) begin
      byteValid = 1'b0;
      tick();
    end
  endtask

  task automatic send_stream(input logic [7:0] bytes[$], input bit gap);
    foreach (bytes[i]) send_byte(bytes[i], gap);
    byteValid = 1'b0;
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic check_status(input string tag, input logic e_done,
                              input logic e_err, input logic e_cpurst,
                              input logic e_busy);
    check({tag, "_done"},   {31'd0, done},   {31'd0, e_done});
    check({tag, "_err"},    {31'd0, err},    {31'd0, e_err});
    check({tag, "_cpuRst"}, {31'd0, cpuRst}, {31'd0, e_cpurst});
    check({tag, "_busy"},   {31'd0, busy},   {31'd0, e_busy});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_byteReady"}, {31'd0, byteReady}, 32'd0);
    check({tag, "_addrWr"},    {24'd0, addrWr},    32'd0);
    check({tag, "_dataWr"},    {16'd0, dataWr},    32'd0);
    check({tag, "_wrEn"},      {31'd0, wrEn},      32'd0);
    check_status(tag, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Watchdog on the whole run.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [7:0] s[$];
    logic [7:0] chk;
    int         base;
    int         cycles;

    // ---- reset ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    tick();

    // ---- nominal two-word load, gaps between bytes ----
    pulse_start();
    check("start_busy",  {31'd0, busy},      32'd1);
    check("start_ready", {31'd0, byteReady}, 32'd1);
    push_wr(8'd0, 16'hA510);
    push_wr(8'd1, 16'h0000);
    s = '{8'h02, 8'hA5, 8'h10, 8'h00, 8'h00, 8'hB7};
    send_stream(s, 1'b1);
    check_status("nominal", 1'b1, 1'b0, 1'b0, 1'b0);
    check("nominal_sb_empty", exp_q.size(), 32'd0);

    // ---- bad checksum ----
    pulse_start();
    check("restart_done_cleared", {31'd0, done}, 32'd0);
    push_wr(8'd0, 16'hA510);
    push_wr(8'd1, 16'h0000);
    s = '{8'h02, 8'hA5, 8'h10, 8'h00, 8'h00, 8'hB6};
    send_stream(s, 1'b1);
    check_status("badchk", 1'b0, 1'b1, 1'b1, 1'b0);
    check("badchk_sb_empty", exp_q.size(), 32'd0);

    // ---- full 256-word load, valid held high (backpressure in WRITE) ----
    pulse_start();
    base = wr_count;
    s    = '{8'h00};
    chk  = 8'h00;
    for (int i = 0; i < 256; i++) begin
      s.push_back(8'(i));
      s.push_back(8'(i) ^ 8'h5A);
      push_wr(8'(i), {8'(i), 8'(i) ^ 8'h5A});
    end
    foreach (s[i]) chk ^= s[i];
    s.push_back(chk);
    send_stream(s, 1'b0);
    check_status("full", 1'b1, 1'b0, 1'b0, 1'b0);
    check("full_wr_count", wr_count - base, 32'd256);
    check("full_addr_wrap", {24'd0, addrWr}, 32'd0);
    check("full_sb_empty", exp_q.size(), 32'd0);

    // ---- timeout: LEN=1, HI=0x33, then silence ----
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h33, 1'b0);
    byteValid = 1'b0;
    cycles = 0;
    while (err !== 1'b1 && cycles < T + 10) begin
      tick();
      cycles++;
    end
    check("tmo_cycles", cycles, T);
    check_status("tmo", 1'b0, 1'b1, 1'b1, 1'b0);

    // ---- byte arrives on the final watchdog cycle ----
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h33, 1'b0);
    byteValid = 1'b0;
    repeat (T - 1) tick();
    check("tmo_edge_pre_err", {31'd0, err}, 32'd0);
    push_wr(8'd0, 16'h3344);
    send_byte(8'h44, 1'b0);
    byteValid = 1'b0;
    check("tmo_edge_post_err", {31'd0, err}, 32'd0);
    send_byte(8'h76, 1'b1);  // 01 ^ 33 ^ 44
    check_status("tmo_edge", 1'b1, 1'b0, 1'b0, 1'b0);

    // ---- start pulsed mid-load, valid held continuously ----
    pulse_start();
    push_wr(8'd0, 16'h1122);
    push_wr(8'd1, 16'h3344);
    push_wr(8'd2, 16'h5500);
    send_byte(8'h03, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    start = 1'b1;             // lands while waiting for the LO byte
    send_byte(8'h44, 1'b0);
    start = 1'b0;
    check("midstart_busy", {31'd0, busy}, 32'd1);
    s = '{8'h55, 8'h00, 8'h03 ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44 ^ 8'h55};
    send_stream(s, 1'b0);
    check_status("midstart", 1'b1, 1'b0, 1'b0, 1'b0);
    check("midstart_sb_empty", exp_q.size(), 32'd0);

    // ---- reset after the HI byte of word 1 ----
    pulse_start();
    push_wr(8'd0, 16'hC3D4);
    s = '{8'h02, 8'hC3, 8'hD4, 8'hE5};
    send_stream(s, 1'b0);
    rst = 1'b1;
    tick();
    check_reset_values("midrst");
    check("midrst_sb_empty", exp_q.size(), 32'd0);
    rst = 1'b0;
    tick();
    pulse_start();
    push_wr(8'd0, 16'hA510);
    push_wr(8'd1, 16'h0000);
    s = '{8'h02, 8'hA5, 8'h10, 8'h00, 8'h00, 8'hB7};
    send_stream(s, 1'b1);
    check_status("postrst", 1'b1, 1'b0, 1'b0, 1'b0);
    check("postrst_sb_empty", exp_q.size(), 32'd0);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
